// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin bus arbiter.
// Latency: none (types and constants only).
// Backpressure: none.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GRANT = 2'b01,
        ARB_TURN  = 2'b10
    } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority pick: first set req bit searching from ptr upward, mod 4.
// Latency: combinational.
// Backpressure: none; valid is simply |req.
//
// Ports:
//   req   in  4  request vector
//   ptr   in  2  index with highest priority this cycle
//   valid out 1  at least one request is set
//   idx   out 2  winning request index
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               valid,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit to ptr
    // is the last one written and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr4.sv
// Round-robin owner selection for a shared 4:1 bus mux with hold limit and turnaround gap.
// Latency: request sampled at one edge is granted at the next edge; release takes one edge plus one TURN cycle.
// Backpressure: a pending request waits; the owner is released on its own drop or when the hold limit hits under contention.
//
// Ports:
//   clock       in   1      rising-edge clock
//   clear       in   1      synchronous active-low reset
//   req         in   4      request per source (bit i = mux data i)
//   grant       out  4      one-hot grant, 0 when bus is free
//   mux_select  out  2      binary owner index, holds when bus is free
//   mux_enable  out  1      high while a grant is active
//   bus_busy    out  1      high in GRANT state
//   owner_cnt   out  CNT_W  cycles the current owner has held the bus, saturating
module bus_arbiter_rr4
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   mux_select,
    output logic               mux_enable,
    output logic               bus_busy,
    output logic [CNT_W-1:0]   owner_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_t         state, state_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic               en_nxt;
    logic [CNT_W-1:0]   cnt_nxt;

    logic               pick_vld;
    logic [SEL_W-1:0]   pick_idx;
    logic               release_now;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // The owner lets go when it drops its request, or when it has used up
    // its hold budget while someone else is waiting.
    always_comb begin
        release_now = !req[mux_select];
        if ((MAX_HOLD != 0) && (owner_cnt >= HOLD_LIM) && ((req & ~grant) != '0))
            release_now = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant;
        sel_nxt   = mux_select;
        en_nxt    = mux_enable;
        cnt_nxt   = owner_cnt;
        unique case (state)
            ARB_GRANT: begin
                if (release_now) begin
                    state_nxt = ARB_TURN;
                    grant_nxt = '0;
                    en_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    ptr_nxt   = mux_select + SEL_W'(1);
                end else if (owner_cnt != CNT_MAX) begin
                    cnt_nxt = owner_cnt + CNT_W'(1);
                end
            end
            ARB_IDLE, ARB_TURN: begin
                if (pick_vld) begin
                    state_nxt = ARB_GRANT;
                    grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    sel_nxt   = pick_idx;
                    en_nxt    = 1'b1;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    // mux_select keeps its last value while the bus is free
                    state_nxt = ARB_IDLE;
                    grant_nxt = '0;
                    en_nxt    = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
                en_nxt    = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state      <= ARB_IDLE;
            ptr        <= '0;
            grant      <= '0;
            mux_select <= '0;
            mux_enable <= 1'b0;
            bus_busy   <= 1'b0;
            owner_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            grant      <= grant_nxt;
            mux_select <= sel_nxt;
            mux_enable <= en_nxt;
            bus_busy   <= en_nxt;
            owner_cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Directed bench for bus_arbiter_rr4 with MAX_HOLD=4.
// Inputs change 1 time unit after each rising edge; outputs checked there too.
// Per-cycle invariants are checked on the falling edge.
module tb_bus_arbiter_rr4;

    logic       clock;
    logic       clear;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] mux_select;
    logic       mux_enable;
    logic       bus_busy;
    logic [3:0] owner_cnt;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    bus_arbiter_rr4 #(
        .NUM_REQ  (4),
        .MAX_HOLD (4),
        .CNT_W    (4)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .req        (req),
        .grant      (grant),
        .mux_select (mux_select),
        .mux_enable (mux_enable),
        .bus_busy   (bus_busy),
        .owner_cnt  (owner_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_free(input string tag, input logic [1:0] sel);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_en"},    32'(mux_enable), 32'h0);
        check({tag, "_busy"},  32'(bus_busy), 32'h0);
        check({tag, "_cnt"},   32'(owner_cnt), 32'h0);
        check({tag, "_sel"},   32'(mux_select), 32'(sel));
    endtask

    task automatic expect_own(input string tag, input logic [1:0] o, input logic [3:0] cnt);
        logic [3:0] g;
        g = 4'b0001 << o;
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_sel"},   32'(mux_select), 32'(o));
        check({tag, "_en"},    32'(mux_enable), 32'h1);
        check({tag, "_busy"},  32'(bus_busy), 32'h1);
        check({tag, "_cnt"},   32'(owner_cnt), 32'(cnt));
    endtask

    always @(negedge clock) begin
        if (started) begin
            check("inv_onehot", 32'($onehot0(grant)), 32'h1);
            check("inv_en",     32'(mux_enable), 32'(|grant));
            check("inv_busy",   32'(bus_busy), 32'(mux_enable));
            check("inv_sel",    32'((grant == 4'b0000) || (grant == (4'b0001 << mux_select))), 32'h1);
        end
    end

    initial begin
        logic [1:0] owners [5];
        owners[0] = 2'd0; owners[1] = 2'd1; owners[2] = 2'd2;
        owners[3] = 2'd3; owners[4] = 2'd0;

        // 1. reset with all requests high
        clear = 1'b0;
        req   = 4'b1111;
        step();
        started = 1;
        step();
        expect_free("reset", 2'd0);

        // 2. single requester 2, held for 5 grant cycles
        clear = 1'b1;
        req   = 4'b0000;
        step();                       // edge 0, still idle
        check("idle_grant", 32'(grant), 32'h0);
        req = 4'b0100;
        step();                       // edge 1
        expect_own("single_e1", 2'd2, 4'd1);
        step(); step(); step(); step(); // edge 5
        expect_own("single_e5", 2'd2, 4'd5);
        req = 4'b0000;
        step();                       // edge 6: TURN
        expect_free("single_turn", 2'd2);
        step();                       // edge 7: IDLE, select held
        expect_free("single_idle", 2'd2);

        // 3. full contention after reset: 0,1,2,3,0, four cycles each, one gap
        clear = 1'b0;
        step();
        clear = 1'b1;
        req   = 4'b1111;
        step();
        foreach (owners[n]) begin
            for (int c = 1; c <= 4; c++) begin
                expect_own($sformatf("rr_o%0d_c%0d", n, c), owners[n], 4'(c));
                step();
            end
            expect_free($sformatf("rr_gap%0d", n), owners[n]);
            step();
        end

        // 4. hold limit without contention, counter saturates
        clear = 1'b0;
        req   = 4'b0001;
        step();
        clear = 1'b1;
        step();
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("hold_grant_c%0d", c), 32'(grant), 32'h1);
            check($sformatf("hold_cnt_c%0d", c), 32'(owner_cnt), (c > 15) ? 32'd15 : 32'(c));
            step();
        end

        // 5. reset while source 3 owns the bus
        req = 4'b1000;
        step();                       // source 0 releases, ptr=1
        expect_free("pre3_turn", 2'd0);
        step();
        expect_own("own3_c1", 2'd3, 4'd1);
        step();
        expect_own("own3_c2", 2'd3, 4'd2);
        clear = 1'b0;
        req   = 4'b1001;
        step();
        expect_free("midreset", 2'd0);
        clear = 1'b1;
        step();
        expect_own("after_reset", 2'd0, 4'd1);

        // 6. owner 2 releases (ptr=3), then pointer wraps to source 0
        req = 4'b0100;
        step();                       // source 0 releases, ptr=1
        expect_free("wrap_turn0", 2'd0);
        step();
        expect_own("wrap_own2", 2'd2, 4'd1);
        req = 4'b0011;
        step();                       // source 2 releases, ptr=3
        expect_free("wrap_turn2", 2'd2);
        step();
        expect_own("wrap_own0", 2'd0, 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
